// File: rtl/fetch_stage_q_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the memory subsystem (slave).
interface fetch_stage_q_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage_q.sv
// Decoupled instruction fetch: PC issues pipelined imem requests, responses land in a prefetch
// queue towards ID. Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_stage_q #(
  parameter int                DATA_W          = 32,
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0,
  parameter int                QUEUE_DEPTH     = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic                _clk,
  input  logic                _reset,
  input  logic                _pcWrite,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  fetch_stage_q_if.master     imem,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_instr,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [ADDR_W-1:0]   if_pc_next,
  input  logic                id_ready,
  output logic                fetch_fault
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W+1)'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0]  OUTS_LIM  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [TAG_W-1:0]  TAG_ONE   = TAG_W'(1);
  localparam logic [TAG_W-1:0]  TAG_LAST  = TAG_W'(MAX_OUTSTANDING - 1);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target_pc;
  logic              misalign;
  logic              fault;

  logic [CNT_W-1:0]  occ, occ_nxt;
  logic [CNT_W-1:0]  outst, outst_nxt;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W:0]    in_flight;

  logic [PTR_W-1:0]  q_head, q_tail;
  logic [DATA_W-1:0] q_instr [QUEUE_DEPTH];
  logic [ADDR_W-1:0] q_pc    [QUEUE_DEPTH];

  logic [ADDR_W-1:0] tag_pc  [MAX_OUTSTANDING];
  logic [TAG_W-1:0]  tag_rd, tag_wr;

  logic accept, resp_live, resp_drop, push, pop;

  function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] p);
    return (p == TAG_LAST) ? '0 : p + TAG_ONE;
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_pc = redirect_pc;
  assign misalign  = |redirect_pc[1:0];
`else
  assign target_pc = redirect_pc & ~ADDR_W'(3);
  assign misalign  = 1'b0;
`endif

  assign fetch_fault = fault;

  // Issue is budgeted against queue space so every live response is guaranteed a slot.
  always_comb begin
    in_flight      = {1'b0, occ} + {1'b0, outst};
    imem.imem_req  = _reset && _pcWrite && !redirect_valid && !fault &&
                     (in_flight < DEPTH_LIM) && (outst < OUTS_LIM);
    imem.imem_addr = pc;
    accept         = imem.imem_req && imem.imem_ready;
    resp_live      = imem.imem_rvalid && (discard == '0);
    resp_drop      = imem.imem_rvalid && (discard != '0);
    push           = resp_live && !redirect_valid;
    pop            = if_valid && id_ready && !redirect_valid;
  end

  always_comb begin
    outst_nxt = outst;
    if (accept)           outst_nxt = outst_nxt + CNT_ONE;
    if (imem.imem_rvalid) outst_nxt = outst_nxt - CNT_ONE;
    occ_nxt = occ;
    if (push) occ_nxt = occ_nxt + CNT_ONE;
    if (pop)  occ_nxt = occ_nxt - CNT_ONE;
  end

  always_ff @(posedge _clk or negedge _reset) begin
    if (!_reset) begin
      pc      <= RESET_PC;
      occ     <= '0;
      outst   <= '0;
      discard <= '0;
      q_head  <= '0;
      q_tail  <= '0;
      tag_rd  <= '0;
      tag_wr  <= '0;
      fault   <= 1'b0;
    end else begin
      outst <= outst_nxt;
      if (redirect_valid) begin
        // Everything still in flight is stale; a response landing now is dropped on the spot.
        pc      <= target_pc;
        discard <= imem.imem_rvalid ? outst - CNT_ONE : outst;
        occ     <= '0;
        q_head  <= '0;
        q_tail  <= '0;
        tag_rd  <= '0;
        tag_wr  <= '0;
        fault   <= misalign;
      end else begin
        if (accept) begin
          pc     <= pc + PC_STEP;
          tag_wr <= tag_next(tag_wr);
        end
        if (resp_drop) discard <= discard - CNT_ONE;
        if (resp_live) tag_rd  <= tag_next(tag_rd);
        if (push)      q_tail  <= q_tail + PTR_ONE;
        if (pop)       q_head  <= q_head + PTR_ONE;
        occ <= occ_nxt;
      end
    end
  end

  always_ff @(posedge _clk) begin
    if (accept) tag_pc[tag_wr] <= pc;
    if (push) begin
      q_instr[q_tail] <= imem.imem_rdata;
      q_pc[q_tail]    <= tag_pc[tag_rd];
    end
  end

  always_comb begin
    if_valid   = (occ != '0);
    if_instr   = if_valid ? q_instr[q_head]        : '0;
    if_pc      = if_valid ? q_pc[q_head]           : '0;
    if_pc_next = if_valid ? q_pc[q_head] + PC_STEP : '0;
  end

endmodule

// File: tb/tb_fetch_stage_q.sv
// Self-checking bench for fetch_stage_q: in-order memory model plus a queue-level model of the
// PC stream delivered to ID, with directed scenarios and a randomized soak.
`timescale 1ns/1ps
module tb_fetch_stage_q;

  typedef logic [31:0] word_q_t[$];
  typedef struct { logic [31:0] addr; int unsigned due; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcw;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc_next;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_stage_q_if #(.DATA_W(32), .ADDR_W(32)) imem ();

  fetch_stage_q #(
    .DATA_W(32), .ADDR_W(32), .RESET_PC(32'h0), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    ._clk(clk), ._reset(rst_n), ._pcWrite(pcw),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(imem),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_next(if_pc_next),
    .id_ready(id_ready), .fetch_fault(fetch_fault)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  pend_t       pending[$];
  ent_t        mq[$];
  logic [31:0] exp_pc;
  bit          exp_fault;
  int unsigned cyc, last_due;
  int unsigned lat_min, lat_max;
  int          first_valid;
  word_q_t     acc_log, del_log;

  bit          s_pcw, s_redir, s_idr, s_rdy;
  logic [31:0] s_rpc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pin_at(input string name, input word_q_t q, input int idx, input logic [31:0] exp);
    if (idx < q.size()) check(name, q[idx], exp);
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: entry %0d missing (have %0d) expected 0x%08h", name, idx, q.size(), exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pcw = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem.imem_ready = 1'b1; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    #1;
    check("rst imem_req",   32'(imem.imem_req), 32'd0);
    check("rst imem_addr",  imem.imem_addr, 32'h0);
    check("rst if_valid",   32'(if_valid), 32'd0);
    check("rst if_instr",   if_instr, 32'h0);
    check("rst if_pc",      if_pc, 32'h0);
    check("rst if_pc_next", if_pc_next, 32'h0);
    check("rst fault",      32'(fetch_fault), 32'd0);
    pending.delete(); mq.delete(); acc_log.delete(); del_log.delete();
    exp_pc = 32'h0; exp_fault = 1'b0; cyc = 0; last_due = 0; first_valid = -1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst hold imem_req", 32'(imem.imem_req), 32'd0);
  endtask

  // One clock: drive at negedge, compare 1ns later, then advance the model to the next cycle.
  task automatic cycle();
    bit          rv, exp_req, acc_dut, acc_mod, pop;
    pend_t       r;
    ent_t        dummy;
    int unsigned due;
    @(negedge clk);
    rst_n = 1'b1;
    pcw = s_pcw; redirect_valid = s_redir; redirect_pc = s_rpc; id_ready = s_idr;
    imem.imem_ready  = s_rdy;
    rv = (pending.size() > 0) && (pending[0].due <= cyc);
    imem.imem_rvalid = rv;
    imem.imem_rdata  = rv ? instr_of(pending[0].addr) : $urandom;
    #1;
    exp_req = s_pcw && !s_redir && !exp_fault &&
              (mq.size() + pending.size() < 4) && (pending.size() < 2);
    check("imem_req",  32'(imem.imem_req), 32'(exp_req));
    check("imem_addr", imem.imem_addr, exp_pc);
    check("if_valid",  32'(if_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("if_pc",      if_pc, mq[0].pc);
      check("if_instr",   if_instr, mq[0].instr);
      check("if_pc_next", if_pc_next, mq[0].pc + 32'd4);
    end
    check("fetch_fault", 32'(fetch_fault), 32'(exp_fault));

    acc_dut = imem.imem_req && s_rdy;
    if (acc_dut) acc_log.push_back(imem.imem_addr);
    if (if_valid && s_idr && !s_redir) del_log.push_back(if_pc);
    if (if_valid && first_valid < 0) first_valid = int'(cyc);

    acc_mod = exp_req && s_rdy;
    pop     = (mq.size() > 0) && s_idr && !s_redir;
    if (rv) r = pending.pop_front();
    if (s_redir) begin
      mq.delete();
      foreach (pending[i]) pending[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_pc    = s_rpc;
      exp_fault = (s_rpc[1:0] != 2'b00);
`else
      exp_pc    = s_rpc & ~32'd3;
`endif
    end else begin
      if (pop) dummy = mq.pop_front();
      if (rv && !r.stale) mq.push_back('{pc: r.addr, instr: instr_of(r.addr)});
      if (acc_mod) exp_pc = exp_pc + 32'd4;
    end
    if (acc_dut) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pending.push_back('{addr: imem.imem_addr, due: due, stale: 1'b0});
    end
    cyc++;
  endtask

  task automatic idle_stim(input int unsigned lat);
    s_pcw = 1'b1; s_redir = 1'b0; s_rpc = '0; s_idr = 1'b1; s_rdy = 1'b1;
    lat_min = lat; lat_max = lat;
  endtask

  initial begin
    rst_n = 1'b0; pcw = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    idle_stim(1);

    // Streaming with single-cycle memory.
    do_reset();
    idle_stim(1);
    repeat (6) cycle();
    check("A first valid cycle", 32'(first_valid), 32'd2);
    pin_at("A acc0", acc_log, 0, 32'h0);
    pin_at("A acc1", acc_log, 1, 32'h4);
    pin_at("A acc2", acc_log, 2, 32'h8);
    pin_at("A del0", del_log, 0, 32'h0);
    pin_at("A del1", del_log, 1, 32'h4);
    pin_at("A del2", del_log, 2, 32'h8);

    // ID stalled: issue stops once the queue budget is spent.
    do_reset();
    idle_stim(1);
    s_idr = 1'b0;
    repeat (10) cycle();
    check("B accepts", 32'(acc_log.size()), 32'd4);
    check("B pc", imem.imem_addr, 32'h10);
    check("B req low", 32'(imem.imem_req), 32'd0);
    s_idr = 1'b1;
    repeat (8) cycle();
    pin_at("B del0", del_log, 0, 32'h0);
    pin_at("B del1", del_log, 1, 32'h4);
    pin_at("B del2", del_log, 2, 32'h8);
    pin_at("B del3", del_log, 3, 32'hC);
    pin_at("B del4", del_log, 4, 32'h10);

    // Redirect with two requests in flight on 3-cycle memory.
    do_reset();
    idle_stim(3);
    repeat (6) cycle();
    check("C acc count", 32'(acc_log.size()), 32'd4);
    s_redir = 1'b1; s_rpc = 32'h100;
    cycle();
    s_redir = 1'b0;
    repeat (12) cycle();
    pin_at("C del0", del_log, 0, 32'h0);
    pin_at("C del1", del_log, 1, 32'h4);
    pin_at("C del2", del_log, 2, 32'h100);

    // Redirect together with a returning response and an ID pop.
    do_reset();
    idle_stim(1);
    repeat (4) cycle();
    s_redir = 1'b1; s_rpc = 32'h40;
    cycle();
    s_redir = 1'b0;
    cycle();
    check("E valid c5", 32'(if_valid), 32'd0);
    cycle();
    check("E valid c6", 32'(if_valid), 32'd0);
    cycle();
    check("E valid c7", 32'(if_valid), 32'd1);
    check("E pc c7", if_pc, 32'h40);

    // Misaligned redirect target.
    do_reset();
    idle_stim(1);
    repeat (2) cycle();
    s_redir = 1'b1; s_rpc = 32'h102;
    cycle();
    s_redir = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (4) begin
      cycle();
      check("F fault set", 32'(fetch_fault), 32'd1);
      check("F req blocked", 32'(imem.imem_req), 32'd0);
    end
    s_redir = 1'b1; s_rpc = 32'h200;
    cycle();
    s_redir = 1'b0;
    cycle();
    check("F fault clear", 32'(fetch_fault), 32'd0);
    check("F resume req", 32'(imem.imem_req), 32'd1);
    check("F resume addr", imem.imem_addr, 32'h200);
`else
    cycle();
    check("F aligned req", 32'(imem.imem_req), 32'd1);
    check("F aligned addr", imem.imem_addr, 32'h100);
    check("F no fault", 32'(fetch_fault), 32'd0);
`endif
    repeat (4) cycle();

    // Randomized soak with mid-run resets.
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      lat_min = 1; lat_max = 4;
      for (int n = 0; n < 1000; n++) begin
        s_pcw   = ($urandom_range(9, 0) != 0);
        s_idr   = ($urandom_range(3, 0) != 0);
        s_rdy   = ($urandom_range(2, 0) != 0);
        s_redir = ($urandom_range(24, 0) == 0) || (n > 0 && n % 97 == 0);
        s_rpc   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : {18'h0, 12'($urandom), 2'b00};
        if ($urandom_range(3, 0) == 0) s_rpc[1:0] = 2'($urandom);
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage_q.md
Name: fetch_stage_q

Overview:
Parametrised instruction-fetch stage for the MUSA pipeline. It replaces the single-cycle PC/adder/instruction-memory fetch with a decoupled front end. A PC register drives a pipelined instruction-memory request/response interface, and a small prefetch queue buffers fetched words towards ID with a valid/ready handshake. Branch/jump redirects flush the queue and discard stale in-flight responses.

Parameters:
DATA_W, 32, instruction word width
ADDR_W, 32, PC/address width
RESET_PC, 0, PC value loaded on reset
QUEUE_DEPTH, 4, prefetch queue entries (power of two, >=2)
MAX_OUTSTANDING, 2, max issued-but-unreturned memory requests (1..QUEUE_DEPTH)

Ports:
_clk  in  1  clock, rising edge
_reset  in  1  asynchronous, active-low reset
_pcWrite  in  1  fetch enable; 0 freezes request issue (PC holds), queue still drains
redirect_valid  in  1  redirect PC this cycle (branch/jump taken)
redirect_pc  in  ADDR_W  redirect target
imem_req  out  1  request valid
imem_addr  out  ADDR_W  request address (= current PC)
imem_ready  in  1  memory accepts request when imem_req && imem_ready
imem_rvalid  in  1  response valid, in request order, >=1 cycle after acceptance
imem_rdata  in  DATA_W  response instruction
if_valid  out  1  queue head valid to ID
if_instr  out  DATA_W  head instruction
if_pc  out  ADDR_W  head PC
if_pc_next  out  ADDR_W  if_pc + 4 (mod 2^ADDR_W)
id_ready  in  1  ID consumes head when if_valid && id_ready
fetch_fault  out  1  misaligned-redirect fault (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): PC=RESET_PC, queue empty, outstanding=0, discard=0, imem_req=0, if_valid=0, fault=0; if_instr/if_pc/if_pc_next=0.
- imem_req = _pcWrite && !redirect_valid && !fault && (occupancy + outstanding) < QUEUE_DEPTH && outstanding < MAX_OUTSTANDING. Combinational; imem_addr=PC.
- On accept: PC <= PC+4 (wraps), outstanding+1. Each request stores its PC in an in-order tag FIFO (depth MAX_OUTSTANDING).
- Response with discard==0: push {rdata, tag PC} into queue; outstanding-1. Space is guaranteed by the issue rule; overflow is impossible.
- Response with discard>0: dropped, discard-1, outstanding-1.
- Queue: FIFO, registered outputs from head; pop on if_valid && id_ready. Push and pop in the same cycle keep occupancy. Empty-queue response appears on if_valid next cycle (min fetch latency: request cycle + memory latency + 1).
- Redirect (highest priority): PC <= redirect_pc; queue flushed (if_valid=0 next cycle); discard <= outstanding (excluding any response returning this cycle, which is itself dropped); tag FIFO cleared; no request issued that cycle; ID pop that cycle is ignored.
- Back-to-back redirects: each reloads PC; discard accumulates correctly across them.
- _pcWrite=0: no issue; responses still land; ID still drains.
- Reset mid-operation: all state cleared immediately. The memory subsystem shares the reset, so no stale responses are expected.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky) and blocks issue. The flush occurs as normal. The next aligned redirect clears the fault and resumes fetching.
- Undefined: redirect_pc[1:0] forced to 00; fetch_fault tied 0.

Test Plan:
- Reset, RESET_PC=0x0, 1-cycle memory, id_ready=1 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; if_pc 0x0,0x4,0x8 with if_pc_next 0x4,0x8,0xC; if_valid first high 2 cycles after reset release.
- id_ready=0 for 10 cycles, depth 4 -> exactly 4 requests accepted, imem_req low thereafter; PC=0x10; queue holds 0x0..0xC in order.
- Redirect to 0x100 with 2 outstanding, 3-cycle memory -> both responses dropped; first if_pc delivered is 0x100; no 0x8/0xC seen at ID.
- imem_ready toggling 1,0,1,0 with _pcWrite=0 mid-sequence -> PC advances only on accepted requests; no duplicate or skipped PC at ID.
- Redirect coinciding with imem_rvalid and an ID pop -> response dropped; if_valid=0 next cycle; following valid is the redirect target.
- FETCH_MISALIGN_TRAP_EN defined: redirect to 0x102 -> fetch_fault=1, imem_req stays 0; redirect to 0x200 -> fault=0, fetch resumes at 0x200. Undefined: 0x102 fetches 0x100.
